// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU.
// Opcode map and control FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_INC = 4'h3,
    OP_DEC = 4'h4,
    OP_OR  = 4'h5,
    OP_AND = 4'h6,
    OP_XOR = 4'h7,
    OP_SHR = 4'h8,
    OP_SHL = 4'h9,
    OP_NOT = 4'hA,
    OP_NEG = 4'hB,
    OP_ADC = 4'hC,
    OP_SBC = 4'hD,
    OP_MUL = 4'hE,
    OP_ILL = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-add multiplier.
// One partial product per cycle, WIDTH cycles per start.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic               run;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // prod is the accumulator after the step taken this cycle
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      run    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= '0;
      run    <= 1'b1;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes.
// Single-cycle ops plus a sequential multiply.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zero,
  output logic             alu_carry,
  output logic             alu_ovf,
  output logic             alu_err
);

  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  state_e             state;
  op_e                op;
  logic               carry_q;
  logic               cq_eff;
  logic               accept;
  logic               retire;
  logic [WIDTH:0]     y;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     res;
  logic               cin;
  logic               arith;
  logic               ovf;
  logic               err;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;

  assign op        = op_e'(opcode);
  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign mul_start = accept && (op == OP_MUL);

  // an op accepted while the previous one retires sees its carry
  assign cq_eff = (retire && !alu_err) ? alu_carry : carry_q;

  always_comb begin
    y     = '0;
    cin   = 1'b0;
    arith = 1'b0;
    err   = 1'b0;
    res   = '0;
    sum   = '0;
    ovf   = 1'b0;
    unique case (op)
      OP_ADD: begin y = {1'b0, in_b};  arith = 1'b1; end
      OP_SUB: begin y = {1'b0, ~in_b}; cin = 1'b1; arith = 1'b1; end
      OP_INC: begin cin = 1'b1; arith = 1'b1; end
      OP_DEC: begin y = {1'b0, {WIDTH{1'b1}}}; arith = 1'b1; end
      OP_ADC: begin y = {1'b0, in_b};  cin = cq_eff; arith = 1'b1; end
      OP_SBC: begin y = {1'b0, ~in_b}; cin = cq_eff; arith = 1'b1; end
      OP_OR:  res = {1'b0, in_a | in_b};
      OP_AND: res = {1'b0, in_a & in_b};
      OP_XOR: res = {1'b0, in_a ^ in_b};
      OP_SHR: res = {in_a[0], 1'b0, in_a[WIDTH-1:1]};
      OP_SHL: res = {in_a, 1'b0};
      OP_NOT: res = {1'b0, ~in_a};
      OP_NEG: res = {1'b0, ~in_a} + ONE;
      OP_MUL: res = '0;
      default: err = 1'b1;
    endcase
    sum = {1'b0, in_a} + y + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      res = sum;
      ovf = (in_a[WIDTH-1] == y[WIDTH-1]) &&
            (sum[WIDTH-1] != in_a[WIDTH-1]);
    end
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (in_a),
    .b     (in_b),
    .done  (mul_done),
    .prod  (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_out   <= '0;
      alu_zero  <= 1'b0;
      alu_carry <= 1'b0;
      alu_ovf   <= 1'b0;
      alu_err   <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      if (retire && !alu_err) carry_q <= alu_carry;
      unique case (state)
        BUSY: begin
          if (mul_done) begin
            state     <= DONE;
            alu_out   <= prod[WIDTH-1:0];
            alu_zero  <= (prod[WIDTH-1:0] == '0);
            alu_carry <= |prod[2*WIDTH-1:WIDTH];
            alu_ovf   <= 1'b0;
            alu_err   <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              alu_out   <= res[WIDTH-1:0];
              alu_zero  <= (res[WIDTH-1:0] == '0);
              alu_carry <= res[WIDTH];
              alu_ovf   <= ovf;
              alu_err   <= err;
            end
          end else if (retire) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=8 and WIDTH=16.
// Arithmetic reference model plus directed and random ops.
module tb_alu_mc;

  typedef struct {
    longint o;
    bit     c;
    bit     v;
    bit     z;
    bit     e;
  } res_t;

  logic clk;
  logic rst_n;

  logic        iv8, or8, ir8, ov8, z8, c8, v8, e8;
  logic [7:0]  a8, b8, out8;
  logic [3:0]  op8;
  logic        iv16, or16, ir16, ov16, z16, c16, v16, e16;
  logic [15:0] a16, b16, out16;
  logic [3:0]  op16;

  int checks = 0;
  int errors = 0;
  int sel = 8;
  bit cq8 = 0;
  bit cq16 = 0;

  logic        v_ir, v_ov, v_z, v_c, v_v, v_e;
  logic [31:0] v_out;

  assign v_ir  = (sel == 16) ? ir16 : ir8;
  assign v_ov  = (sel == 16) ? ov16 : ov8;
  assign v_z   = (sel == 16) ? z16 : z8;
  assign v_c   = (sel == 16) ? c16 : c8;
  assign v_v   = (sel == 16) ? v16 : v8;
  assign v_e   = (sel == 16) ? e16 : e8;
  assign v_out = (sel == 16) ? {16'h0, out16} : {24'h0, out8};

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .in_a(a8), .in_b(b8), .opcode(op8),
    .out_valid(ov8), .out_ready(or8),
    .alu_out(out8), .alu_zero(z8), .alu_carry(c8),
    .alu_ovf(v8), .alu_err(e8)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .in_a(a16), .in_b(b16), .opcode(op16),
    .out_valid(ov16), .out_ready(or16),
    .alu_out(out16), .alu_zero(z16), .alu_carry(c16),
    .alu_ovf(v16), .alu_err(e16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input int op, input longint a,
                                 input longint b, input bit cq,
                                 input int w);
    res_t   r;
    longint m = (longint'(1) <<< w) - 1;
    longint h = longint'(1) <<< (w - 1);
    longint sa, sb, s, u, p;
    bit     arith = 0;
    r.o = 0; r.c = 0; r.v = 0; r.z = 0; r.e = 0;
    sa = (a >= h) ? a - (m + 1) : a;
    sb = (b >= h) ? b - (m + 1) : b;
    s = 0;
    u = 0;
    case (op)
      1:  begin u = a + b;           s = sa + sb;          arith = 1; end
      2:  begin u = a + (m - b) + 1; s = sa - sb;          arith = 1; end
      3:  begin u = a + 1;           s = sa + 1;           arith = 1; end
      4:  begin u = a + m;           s = sa - 1;           arith = 1; end
      12: begin u = a + b + cq;      s = sa + sb + cq;     arith = 1; end
      13: begin u = a + (m - b) + cq; s = sa - sb - 1 + cq; arith = 1; end
      5:  u = a | b;
      6:  u = a & b;
      7:  u = a ^ b;
      9:  u = a * 2;
      10: u = m - a;
      11: u = (m - a) + 1;
      default: ;
    endcase
    if (op >= 1 && op <= 13 && op != 8) begin
      r.o = u & m;
      r.c = (u > m);
    end else if (op == 8) begin
      r.o = a / 2;
      r.c = a[0];
    end else if (op == 14) begin
      p = a * b;
      r.o = p & m;
      r.c = ((p >>> w) != 0);
    end else begin
      r.e = 1;
    end
    r.v = arith && (s > h - 1 || s < -h);
    r.z = (r.o == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit iv, input bit ordy, input longint a,
                       input longint b, input int op);
    if (sel == 16) begin
      iv16 = iv; or16 = ordy; a16 = 16'(a); b16 = 16'(b); op16 = 4'(op);
    end else begin
      iv8 = iv; or8 = ordy; a8 = 8'(a); b8 = 8'(b); op8 = 4'(op);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, "_out"}, v_out, 32'(e.o));
    chk({tag, "_c"}, {31'h0, v_c}, {31'h0, e.c});
    chk({tag, "_v"}, {31'h0, v_v}, {31'h0, e.v});
    chk({tag, "_z"}, {31'h0, v_z}, {31'h0, e.z});
    chk({tag, "_e"}, {31'h0, v_e}, {31'h0, e.e});
  endtask

  task automatic note_retire(input res_t e);
    if (!e.e) begin
      if (sel == 16) cq16 = e.c;
      else cq8 = e.c;
    end
  endtask

  task automatic run_op(input string tag, input int op, input longint a,
                        input longint b);
    res_t e;
    int   lat;
    bit   cq = (sel == 16) ? cq16 : cq8;
    e = model(op, a, b, cq, sel);
    drive(1, 1, a, b, op);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0);
    lat = 1;
    while (!v_ov && lat < sel + 4) begin
      if (op == 14) chk({tag, "_busy_rdy"}, {31'h0, v_ir}, 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), (op == 14) ? 32'(sel + 1) : 32'd1);
    chk_res(tag, e);
    note_retire(e);
    @(posedge clk); #1;
    chk({tag, "_retired"}, {31'h0, v_ov}, 32'h0);
  endtask

  initial begin
    res_t e;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; op8 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; op16 = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", {31'h0, ov8}, 32'h0);
    chk("rst_ir", {31'h0, ir8}, 32'h1);
    chk("rst_out", {24'h0, out8}, 32'h0);
    chk("rst_flags", {28'h0, z8, c8, v8, e8}, 32'h0);
    rst_n = 1;

    sel = 8;
    run_op("add_ff_01", 1, 'hFF, 'h01);
    run_op("adc_10_20", 12, 'h10, 'h20);
    run_op("add_7f_01", 1, 'h7F, 'h01);
    run_op("mul_10_11", 14, 'h10, 'h11);
    run_op("inc_ff", 3, 'hFF, 0);
    run_op("dec_00", 4, 'h00, 0);
    run_op("op_f", 15, 'h5A, 'h33);
    run_op("op_0", 0, 'hA5, 'h11);

    // hold in DONE, then retire and accept together
    e = model(1, 'hFF, 'h01, cq8, 8);
    drive(1, 0, 'hFF, 'h01, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ov", {31'h0, v_ov}, 32'h1);
      chk("hold_ir", {31'h0, v_ir}, 32'h0);
      chk_res("hold", e);
      @(posedge clk); #1;
    end
    note_retire(e);
    e = model(2, 'h05, 'h07, cq8, 8);
    drive(1, 1, 'h05, 'h07, 2);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0);
    chk("b2b_ov", {31'h0, v_ov}, 32'h1);
    chk_res("b2b_sub", e);
    note_retire(e);
    @(posedge clk); #1;
    chk("b2b_retired", {31'h0, v_ov}, 32'h0);

    for (int i = 0; i < 60; i++) begin
      run_op("rnd8", int'($urandom_range(0, 15)),
             longint'($urandom & 32'hFF), longint'($urandom & 32'hFF));
    end

    // reset in the middle of a multiply
    run_op("pre_rst_add", 1, 'hFF, 'h01);
    drive(1, 1, 'h10, 'h11, 14);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    cq8 = 0;
    cq16 = 0;
    chk("mrst_ov", {31'h0, v_ov}, 32'h0);
    chk("mrst_ir", {31'h0, v_ir}, 32'h1);
    chk("mrst_out", v_out, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_no_result", {31'h0, v_ov}, 32'h0);
    run_op("post_rst_adc", 12, 'h00, 'h00);

    sel = 16;
    run_op("mul16_max", 14, 'hFFFF, 'hFFFF);
    for (int i = 0; i < 20; i++) begin
      run_op("rnd16", int'($urandom_range(0, 15)),
             longint'($urandom & 32'hFFFF), longint'($urandom & 32'hFFFF));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operation is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts an offered operation.
REQ-006 The block SHALL have ports in_a and in_b, input, WIDTH, the operands.
REQ-007 The block SHALL have port opcode, input, 4, the operation select.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result and flags are valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have port alu_out, output, WIDTH, the registered result.
REQ-011 The block SHALL have ports alu_zero, alu_carry, alu_ovf and alu_err, output, 1 each: zero, carry, signed overflow and illegal-opcode flags.

Function
REQ-012 Transfer SHALL occur on in_valid&in_ready (accept) and on out_valid&out_ready (retire); operands and opcode are captured at accept.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE: IDLE->DONE on accept of a single-cycle op; IDLE->BUSY on accept of MUL; BUSY->DONE after WIDTH iterations; DONE->IDLE on retire without a new accept.
REQ-014 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1 (retire and accept in the same cycle, next state per REQ-013), and 0 in BUSY.
REQ-015 out_valid SHALL be 1 exactly in DONE; alu_out and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 Single-cycle op latency SHALL be 1 cycle (out_valid high the cycle after accept); MUL latency SHALL be WIDTH+1 cycles.
REQ-017 Opcodes 1..B SHALL be ADD, SUB, INC, DEC, OR, AND, XOR, SHR, SHL, ONESCOMP and TWOSCOMP.
REQ-018 Each of ADD..TWOSCOMP SHALL compute in a WIDTH+1 result: result[WIDTH] is carry; SUB is a+~b+1; SHR carry=a[0], MSB fill 0; SHL carry=a[WIDTH-1].
REQ-019 Opcode C (ADC) SHALL compute a+b+carry_q.
REQ-020 Opcode D (SBC) SHALL compute a+~b+carry_q, where carry_q is the alu_carry of the last retired op (0 after reset).
REQ-021 Opcode E (MUL) SHALL be an unsigned shift-add over WIDTH cycles: alu_out = low WIDTH bits of a*b, alu_carry = 1 if any high WIDTH bits are nonzero, alu_ovf=0.
REQ-022 alu_zero SHALL be 1 iff alu_out==0, for every op.
REQ-023 alu_ovf SHALL be the signed overflow for ADD/SUB/ADC/SBC/INC/DEC, and 0 for all other ops.
REQ-024 Opcodes 0 and F SHALL give alu_out=0, alu_carry=0, alu_ovf=0, alu_zero=1 and alu_err=1; alu_err=0 for legal ops; carry_q SHALL be unchanged.
REQ-025 Wrap-around SHALL be modulo 2^WIDTH: INC of all-ones gives 0 with carry=1; DEC of 0 gives all-ones with carry=0 (borrow convention: carry = no borrow).
REQ-026 carry_q SHALL update only at retire.
REQ-027 in_valid while in_ready=0 SHALL be ignored (the producer holds it).

Reset
REQ-028 On rst_n=0 at a clock edge the block SHALL enter IDLE with out_valid=0, in_ready=1, alu_out=0, all flags 0, carry_q=0 and the multiplier counter=0.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation with no retire and no carry_q update.

Structure
REQ-030 Package alu_pkg SHALL hold the opcode enum (4-bit) and the state enum (IDLE/BUSY/DONE).
REQ-031 The multiplier SHALL be sub-module alu_mul_seq (start/done, WIDTH-parametrised, counter with $clog2(WIDTH+1) bits).
REQ-032 The datapath for single-cycle ops SHALL be combinational feeding the output register.

Verification
REQ-033 WIDTH=8, ADD 0xFF+0x01, out_ready=1 -> next cycle out_valid=1, alu_out=0x00, carry=1, zero=1, ovf=0.
REQ-034 ADD 0xFF+0x01 retired, then ADC 0x10+0x20 -> alu_out=0x31, carry=0.
REQ-035 ADD 0x7F+0x01 -> alu_out=0x80, ovf=1.
REQ-036 MUL 0x10*0x11 -> out_valid exactly 9 cycles after accept, alu_out=0x10, carry=1; in_ready=0 throughout BUSY.
REQ-037 out_ready=0 for 5 cycles in DONE -> outputs stable; raising out_ready with in_valid=1 (SUB 0x05-0x07) retires and accepts in one cycle -> alu_out=0xFE, carry=0.
REQ-038 Opcode F -> alu_err=1, alu_out=0. Reset mid-MUL -> IDLE next cycle, out_valid=0, carry_q=0.
REQ-039 WIDTH=16, MUL 0xFFFF*0xFFFF -> out_valid 17 cycles after accept, alu_out=0x0001, carry=1.
